key_recorder: RTL

KEY_RECORDER -- requirements
Module: key_recorder

---
 rtl/recorder_pkg.sv | 31 +++
 rtl/key_recorder_tick_gen.sv | 26 ++
 rtl/key_recorder.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/recorder_pkg.sv
// Shared definitions for the key recorder: FSM state encodings, note/pitch
// field widths, the rest code, entry width helper and the key encoder.
package recorder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_RECORD = 2'b01,
    ST_PLAY   = 2'b10
  } state_t;

  localparam int NOTE_W  = 3;
  localparam int PITCH_W = 2;

  localparam logic [NOTE_W-1:0] NOTE_REST = '0;

  // Stored entry is {note, pitch, duration}
  function automatic int entry_width(input int dur_w);
    return NOTE_W + PITCH_W + dur_w;
  endfunction

  // Lowest pressed key wins; no key pressed encodes as a rest
  function automatic logic [NOTE_W-1:0] encode_note(input logic [6:0] keys);
    logic [NOTE_W-1:0] code;
    code = NOTE_REST;
    for (int i = 6; i >= 0; i--) begin
      if (keys[i]) code = NOTE_W'(i + 1);
    end
    return code;
  endfunction

endpackage

// File: rtl/key_recorder_tick_gen.sv
// Duration prescaler: one-cycle tick every TICK_DIV clocks, restartable
// through clr so the first tick after clr lands exactly TICK_DIV clocks later.
module tick_gen #(
  parameter int TICK_DIV = 1_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic tick
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt;

  // Free-running modulo-TICK_DIV counter, cleared on request
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt <= '0;
    else if (clr || cnt == LAST) cnt <= '0;
    else cnt <= cnt + 1'b1;
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/key_recorder.sv
// Key recorder: samples piano keys into {note,pitch,duration} entries while
// recording and replays them at the recorded tempo.
// Optional build macro KEY_RECORDER_LOOP_EN: playback wraps to entry 0
// after the last entry instead of returning to IDLE.
module key_recorder
  import recorder_pkg::*;
#(
  parameter int TICK_DIV = 1_000_000,
  parameter int DEPTH    = 64,
  parameter int DUR_W    = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [6:0]               key,
  input  logic [1:0]               pitch,
  input  logic                     rec_start,
  input  logic                     play_start,
  input  logic                     stop,
  output logic [2:0]               note_out,
  output logic [1:0]               pitch_out,
  output logic                     note_valid,
  output logic [1:0]               state,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full
);

  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int ENT_W = entry_width(DUR_W);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] LAST_C  = CNT_W'(DEPTH - 1);
  localparam logic [DUR_W-1:0] DUR_MAX = {DUR_W{1'b1}};

`ifdef KEY_RECORDER_LOOP_EN
  localparam bit LOOP_EN = 1'b1;
`else
  localparam bit LOOP_EN = 1'b0;
`endif

  logic [6:0]         key_p0, key_p1;
  logic [1:0]         pitch_p0, pitch_p1;
  logic [NOTE_W-1:0]  note_s;
  state_t             st;
  logic [DUR_W-1:0]   dur;
  logic [NOTE_W-1:0]  cur_note;
  logic [1:0]         cur_pitch;
  logic [IDX_W-1:0]   play_idx, idx_nx, idx_ld;
  logic [DUR_W-1:0]   play_ticks, play_dur;
  logic [ENT_W-1:0]   mem [DEPTH];
  logic [ENT_W-1:0]   ent_ld, wr_data;
  logic               tick, clr, pair_chg;
  logic               wr_stop, wr_chg, wr_sat, wr_en, rec_fill;
  logic               rec_go, rec_end, play_go, play_end, adv, last;

  // Two-flop synchronizer for the asynchronous key/pitch levels
  always_ff @(posedge clk) begin
    key_p0   <= key;
    pitch_p0 <= pitch;
    key_p1   <= key_p0;
    pitch_p1 <= pitch_p0;
  end

  assign note_s   = encode_note(key_p1);
  assign pair_chg = {note_s, pitch_p1} != {cur_note, cur_pitch};

  // Record-side writes: stop flush beats a change write; saturation only
  // applies while the pair is unchanged
  assign wr_stop  = (st == ST_RECORD) && stop && (dur != '0) && !full;
  assign wr_chg   = (st == ST_RECORD) && !stop && pair_chg && (dur != '0);
  assign wr_sat   = (st == ST_RECORD) && !stop && !pair_chg && tick &&
                    (dur == DUR_MAX - 1'b1);
  assign wr_en    = wr_stop || wr_chg || wr_sat;
  assign wr_data  = {cur_note, cur_pitch, wr_sat ? DUR_MAX : dur};
  assign rec_fill = wr_en && (count == LAST_C);

  // Playback sequencing
  assign play_dur = mem[play_idx][DUR_W-1:0];
  assign adv      = (st == ST_PLAY) && tick && (play_ticks == play_dur - 1'b1);
  assign last     = (CNT_W'(play_idx) + 1'b1) == count;
  assign idx_nx   = last ? '0 : play_idx + 1'b1;

  // State-entry events; the prescaler restarts on each of them
  assign rec_go   = (st == ST_IDLE) && rec_start;
  assign play_go  = play_start &&
                    (((st == ST_IDLE) && !rec_start && (count != '0)) ||
                     ((st == ST_PLAY) && !stop));
  assign rec_end  = (st == ST_RECORD) && (stop || rec_fill);
  assign play_end = (st == ST_PLAY) &&
                    (stop || (!play_start && adv && last && !LOOP_EN));
  assign clr      = rec_go || play_go || rec_end || play_end;

  assign idx_ld   = play_go ? '0 : idx_nx;
  assign ent_ld   = mem[idx_ld];

  tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .tick  (tick)
  );

  // Entry storage, written at index count
  always_ff @(posedge clk) begin
    if (wr_en) mem[count[IDX_W-1:0]] <= wr_data;
  end

  // Pair tracking while recording (data only, no reset)
  always_ff @(posedge clk) begin
    if (rec_go || ((st == ST_RECORD) && pair_chg)) begin
      cur_note  <= note_s;
      cur_pitch <= pitch_p1;
    end
  end

  // Main FSM with registered playback outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st         <= ST_IDLE;
      count      <= '0;
      dur        <= '0;
      play_idx   <= '0;
      play_ticks <= '0;
      note_out   <= NOTE_REST;
      pitch_out  <= '0;
      note_valid <= 1'b0;
    end else begin
      case (st)
        ST_IDLE: begin
          if (rec_go) begin
            st    <= ST_RECORD;
            count <= '0;
            dur   <= '0;
          end else if (play_go) begin
            st         <= ST_PLAY;
            play_idx   <= '0;
            play_ticks <= '0;
            note_out   <= ent_ld[ENT_W-1 -: NOTE_W];
            pitch_out  <= ent_ld[DUR_W +: PITCH_W];
            note_valid <= 1'b1;
          end
        end
        ST_RECORD: begin
          if (wr_en) count <= count + 1'b1;
          if (stop || rec_fill) begin
            st  <= ST_IDLE;
            dur <= '0;
          end else if (pair_chg) begin
            dur <= (dur == '0 && tick) ? DUR_W'(1) : '0;
          end else if (tick) begin
            dur <= wr_sat ? '0 : dur + 1'b1;
          end
        end
        ST_PLAY: begin
          if (play_end) begin
            st         <= ST_IDLE;
            note_out   <= NOTE_REST;
            pitch_out  <= '0;
            note_valid <= 1'b0;
          end else if (play_go || adv) begin
            play_idx   <= idx_ld;
            play_ticks <= '0;
            note_out   <= ent_ld[ENT_W-1 -: NOTE_W];
            pitch_out  <= ent_ld[DUR_W +: PITCH_W];
            note_valid <= 1'b1;
          end else if (tick) begin
            play_ticks <= play_ticks + 1'b1;
          end
        end
        default: st <= ST_IDLE;
      endcase
    end
  end

  assign state = st;
  assign full  = (count == DEPTH_C);

endmodule
